grf_scoreboard: RTL

- Hazard controller for the general register file in the 5-stage pipeline (F/D/E/M/W).
- Keeps a shadow copy of the in-flight writers in E, M and W: destination register and remaining cycles until the result is ready (Tnew).
- From this state it generates the D-stage stall and the per-operand forwarding selects.
- It also publishes the W-stage write intent, so the bench can cross-check every register-file write.

---
 rtl/grf_scoreboard_if.sv | 44 ++++
 rtl/grf_scoreboard.sv | 112 +++++++++++
 2 files changed

// File: rtl/grf_scoreboard_if.sv
// +-----------------------------------------------------------------------+
// | grf_scoreboard_if : pipeline <-> GRF hazard scoreboard signal bundle  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface grf_scoreboard_if #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
);
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [TNEW_W-1:0] issue_tnew;
  logic [4:0]        rs_addr;
  logic [TNEW_W-1:0] rs_tuse;
  logic [4:0]        rt_addr;
  logic [TNEW_W-1:0] rt_tuse;
  logic              ext_stall;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_rs;
  logic [1:0]        fwd_rt;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [CNT_W-1:0]  stall_cnt;

  // Pipeline control side.
  modport master (
    output issue_valid, issue_rd, issue_tnew,
    output rs_addr, rs_tuse, rt_addr, rt_tuse,
    output ext_stall, flush,
    input  stall, fwd_rs, fwd_rt, wb_valid, wb_rd, stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rd, issue_tnew,
    input  rs_addr, rs_tuse, rt_addr, rt_tuse,
    input  ext_stall, flush,
    output stall, fwd_rs, fwd_rt, wb_valid, wb_rd, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/grf_scoreboard.sv
// +-----------------------------------------------------------------------+
// | grf_scoreboard : E/M/W writer shadow, D-stall and forwarding selects  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module grf_scoreboard #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  grf_scoreboard_if.slave   bus
);

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  typedef struct packed {
    logic              v;
    logic [4:0]        rd;
    logic [TNEW_W-1:0] tnew;
  } entry_t;

  entry_t           e_q, e_d;
  entry_t           m_q, m_d;
  entry_t           w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  // $0 is hardwired, so a writer targeting it can never be a dependency.
  function automatic logic hit(input entry_t ent, input logic [4:0] addr);
    return ent.v && (ent.rd == addr) && (addr != 5'd0);
  endfunction

  function automatic entry_t age(input entry_t ent);
    entry_t r;
    r = ent;
    if (ent.tnew != '0) begin
      r.tnew = ent.tnew - 1'b1;
    end
    return r;
  endfunction

  generate
    for (genvar i = 0; i < 2; i++) begin : g_operand
      logic [4:0]        addr;
      logic [TNEW_W-1:0] tuse;
      logic              haz;
      logic [1:0]        fwd;

      assign addr = (i == 0) ? bus.rs_addr : bus.rt_addr;
      assign tuse = (i == 0) ? bus.rs_tuse : bus.rt_tuse;

      // Any matching writer may stall; only the youngest one may forward.
      always_comb begin
        haz = (hit(e_q, addr) && (e_q.tnew > tuse)) ||
              (hit(m_q, addr) && (m_q.tnew > tuse)) ||
              (hit(w_q, addr) && (w_q.tnew > tuse));
        fwd = FWD_GRF;
        if (hit(e_q, addr)) begin
          fwd = (e_q.tnew == '0) ? FWD_E : FWD_GRF;
        end else if (hit(m_q, addr)) begin
          fwd = (m_q.tnew == '0) ? FWD_M : FWD_GRF;
        end else if (hit(w_q, addr)) begin
          fwd = (w_q.tnew == '0) ? FWD_W : FWD_GRF;
        end
      end
    end
  endgenerate

  assign stall = g_operand[0].haz | g_operand[1].haz | bus.ext_stall;

  always_comb begin
    e_d         = '0;
    e_d.v       = bus.issue_valid & ~stall & ~bus.flush;
    e_d.rd      = bus.issue_rd;
    e_d.tnew    = bus.issue_tnew;
    m_d         = age(e_q);
    w_d         = age(m_q);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_rs    = g_operand[0].fwd;
  assign bus.fwd_rt    = g_operand[1].fwd;
  assign bus.wb_valid  = w_q.v & (w_q.rd != 5'd0);
  assign bus.wb_rd     = w_q.rd;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
